pipelined_chunk_incdec: RTL

//  Parametrised, pipelined N-bit increment/decrement-by-one unit built from CHUNK-bit carry slices.

---
 rtl/incdec_pkg.sv | 23 ++
 rtl/incdec_slice.sv | 21 ++
 rtl/pipelined_chunk_incdec.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/incdec_pkg.sv
// Package: incdec_pkg
// Shared definitions for the pipelined chunked increment/decrement unit.
//   op_e      : operation select (OP_INC = a+1, OP_DEC = a-1)
//   calc_nch  : number of CHUNK-bit carry slices in a WIDTH-bit operand
//   calc_lat  : number of pipeline stages (slices / slices-per-stage)
// The per-stage record (valid, op, carry, data) depends on WIDTH, so the
// struct itself is declared inside the top module next to its parameters.
package incdec_pkg;

  typedef enum logic {
    OP_INC = 1'b0,
    OP_DEC = 1'b1
  } op_e;

  function automatic int calc_nch(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_lat(input int nch, input int stage_chunks);
    return nch / stage_chunks;
  endfunction

endpackage

// File: rtl/incdec_slice.sv
// Module: incdec_slice
// One CHUNK-bit carry slice: s = a + cin, cout = carry out of the slice.
// Purely combinational; the decrement mode is handled by the caller by
// inverting the operand and result around this slice.
// Ports:
//   a    in  CHUNK  operand bits of this slice
//   cin  in  1      carry into the slice
//   s    out CHUNK  sum bits
//   cout out 1      carry out (set only when a is all-ones and cin = 1)
module incdec_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_chunk_incdec.sv
// Module: pipelined_chunk_incdec
// Pipelined WIDTH-bit +1 / -1 unit built from CHUNK-bit carry slices, with a
// register stage every STAGE_CHUNKS slices and valid/ready handshakes on both
// sides (one result per cycle at full throughput, LAT = WIDTH/(CHUNK*STAGE_CHUNKS)).
// Optional feature macro: SATURATE_EN -- when defined, results clamp instead
// of wrapping (inc of all-ones gives all-ones, dec of zero gives zero) and
// out_co acts as the saturation flag. When undefined, results wrap modulo 2^WIDTH.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   flush      in   1      synchronous drop of every in-flight operation
//   in_valid   in   1      input operation valid
//   in_ready   out  1      unit accepts an operation this cycle
//   in_a       in   WIDTH  operand
//   in_dec     in   1      0 = a+1, 1 = a-1
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_s      out  WIDTH  result
//   out_co     out  1      carry (inc of all-ones) / borrow (dec of zero)
module pipelined_chunk_incdec
  import incdec_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHUNK        = 2,
  parameter int STAGE_CHUNKS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co
);

  localparam int NCH = calc_nch(WIDTH, CHUNK);
  localparam int LAT = calc_lat(NCH, STAGE_CHUNKS);

  // Stage record: the register of stage k holds the carry into slice
  // k*STAGE_CHUNKS, already-finished low slices and still-raw high slices.
  typedef struct packed {
    logic             valid;
    op_e              op;
    logic             carry;
    logic [WIDTH-1:0] data;
  } stage_t;

  if (WIDTH % (CHUNK * STAGE_CHUNKS) != 0) begin : g_bad_width
    $error("pipelined_chunk_incdec: WIDTH must be a multiple of CHUNK*STAGE_CHUNKS");
  end

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    stage_t                 stg_reg;
    stage_t                 src;
    stage_t                 proc;
    logic                   rdy;
    logic                   rdy_next;
    logic [CHUNK-1:0]       ps [STAGE_CHUNKS];
    logic [WIDTH-1:0]       pdata;

    // Stage 0 takes the raw operand with carry-in 1; later stages take the
    // partially processed record of the stage before.
    if (gi == 0) begin : g_src_in
      assign src = '{valid: in_valid, op: op_e'(in_dec), carry: 1'b1, data: in_a};
    end else begin : g_src_prev
      assign src = g_stage[gi-1].proc;
    end

    if (gi == LAT - 1) begin : g_rdy_out
      assign rdy_next = out_ready;
    end else begin : g_rdy_chain
      assign rdy_next = g_stage[gi+1].rdy;
    end

    // A stage may load when empty or when its content moves on this edge;
    // this lets bubbles collapse and a stall back up one stage per cycle.
    assign rdy = !stg_reg.valid || rdy_next;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stg_reg <= '0;
      end else if (flush) begin
        stg_reg.valid <= 1'b0;
      end else if (rdy) begin
        stg_reg <= src;
      end
    end

    // Slices owned by this stage. Decrement is ~(~a + 1): invert in and out
    // so the carry chain is the same increment chain for both modes.
    for (genvar gj = 0; gj < STAGE_CHUNKS; gj++) begin : g_slice
      localparam int LO = (gi * STAGE_CHUNKS + gj) * CHUNK;
      logic [CHUNK-1:0] a_raw;
      logic [CHUNK-1:0] a_in;
      logic [CHUNK-1:0] s_raw;
      logic             cin;
      logic             cout;

      if (gj == 0) begin : g_cin_reg
        assign cin = stg_reg.carry;
      end else begin : g_cin_chain
        assign cin = g_slice[gj-1].cout;
      end

      assign a_raw = stg_reg.data[LO +: CHUNK];
      assign a_in  = (stg_reg.op == OP_DEC) ? ~a_raw : a_raw;

      incdec_slice #(
        .CHUNK(CHUNK)
      ) u_slice (
        .a    (a_in),
        .cin  (cin),
        .s    (s_raw),
        .cout (cout)
      );

      assign ps[gj] = (stg_reg.op == OP_DEC) ? ~s_raw : s_raw;
    end

    always_comb begin
      pdata = stg_reg.data;
      for (int j = 0; j < STAGE_CHUNKS; j++) begin
        pdata[(gi * STAGE_CHUNKS + j) * CHUNK +: CHUNK] = ps[j];
      end
    end

    assign proc = '{valid: stg_reg.valid, op: stg_reg.op,
                    carry: g_slice[STAGE_CHUNKS-1].cout, data: pdata};
  end

  // Flush wins over a concurrent accept, so refuse input during it.
  assign in_ready  = g_stage[0].rdy && !flush;

  // The last stage's slices are evaluated combinationally from its register,
  // so the result holds as long as that register holds (i.e. while stalled).
  assign out_valid = g_stage[LAT-1].proc.valid;
  assign out_co    = g_stage[LAT-1].proc.carry;

`ifdef SATURATE_EN
  // On overflow the operand was all-ones (inc) or zero (dec): clamp there.
  assign out_s = out_co ? {WIDTH{g_stage[LAT-1].proc.op == OP_INC}}
                        : g_stage[LAT-1].proc.data;
`else
  assign out_s = g_stage[LAT-1].proc.data;
`endif

endmodule
